// File: rtl/alarm_pkg.sv
// Shared encodings, frame codes and parameter defaults for the flood alarm scheduler.
package alarm_pkg;

  localparam int unsigned TICK_DIV_DEF      = 500;
  localparam int unsigned CONFIRM_TICKS_DEF = 3;
  localparam int unsigned MUTE_TICKS_DEF    = 8;

  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned FRAME_W = 4;
  localparam int unsigned SPEED_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_NORMAL    = 3'd0,
    ST_WARN      = 3'd1,
    ST_DANGER    = 3'd2,
    ST_FLOOD     = 3'd3,
    ST_EMERGENCY = 3'd4
  } alarm_state_e;

  localparam logic [FRAME_W-1:0] FRAME_FLOOD_BLANK = 4'd6;
  localparam logic [FRAME_W-1:0] FRAME_FLOOD_FULL  = 4'd7;
  localparam logic [FRAME_W-1:0] FRAME_EMERG_A     = 4'd8;
  localparam logic [FRAME_W-1:0] FRAME_EMERG_B     = 4'd9;

  // Highest level skips the stability filter.
  localparam logic [LEVEL_W-1:0] LEVEL_BYPASS = 3'd7;

  // Alarm class for an accepted water level.
  function automatic alarm_state_e level_to_state(input logic [LEVEL_W-1:0] lvl);
    alarm_state_e st;
    case (lvl)
      3'd0:             st = ST_NORMAL;
      3'd1, 3'd2, 3'd3: st = ST_WARN;
      3'd4, 3'd5:       st = ST_DANGER;
      3'd6:             st = ST_FLOOD;
      default:          st = ST_EMERGENCY;
    endcase
    return st;
  endfunction

  // Length in ticks of the current blink/beep phase.
  function automatic logic [2:0] phase_len(input alarm_state_e st, input logic ph,
                                           input logic [SPEED_W-1:0] spd);
    logic [2:0] len;
    case (st)
      ST_WARN:      len = ph ? 3'd3 : 3'd1;
      ST_DANGER:    len = 3'd1;
      ST_FLOOD:     len = 3'd2;
      ST_EMERGENCY: len = (spd == 2'd0) ? 3'd4 : ((spd == 2'd1) ? 3'd2 : 3'd1);
      default:      len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/alarm_scheduler_tick_gen.sv
// Free-running divider: one-clk tick each time the counter wraps.
module tick_gen
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));

  // Divider counter, 0..TICK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Water-level alarm: level filter, alarm FSM, beep/blink patterns, mute and speed control.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
  parameter int unsigned CONFIRM_TICKS = CONFIRM_TICKS_DEF,
  parameter int unsigned MUTE_TICKS    = MUTE_TICKS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level,
  input  logic               mute_pulse,
  input  logic               speed_pulse,
  output logic [STATE_W-1:0] alarm_state,
  output logic [FRAME_W-1:0] frame_sel,
  output logic               beep,
  output logic               muted,
  output logic [SPEED_W-1:0] speed
);

  localparam int unsigned CONF_W = $clog2(CONFIRM_TICKS + 1);
  localparam int unsigned MUTE_W = $clog2(MUTE_TICKS + 1);
  localparam int unsigned PAT_W  = 3;

  logic tick_c;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_c (tick_c)
  );

  logic [LEVEL_W-1:0] cand;
  logic [LEVEL_W-1:0] acc_level;
  logic [CONF_W-1:0]  stable_cnt;

  // Level filter: a new level must hold for CONFIRM_TICKS ticks; top level is taken at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand       <= '0;
      acc_level  <= '0;
      stable_cnt <= '0;
    end else begin
      if (level == LEVEL_BYPASS) begin
        acc_level <= level;
      end else if (stable_cnt == CONF_W'(CONFIRM_TICKS)) begin
        acc_level <= cand;
      end
      if (level != cand) begin
        cand       <= level;
        stable_cnt <= '0;
      end else if (tick_c && (stable_cnt != CONF_W'(CONFIRM_TICKS))) begin
        stable_cnt <= stable_cnt + CONF_W'(1);
      end
    end
  end

  alarm_state_e       state, state_nxt;
  logic [PAT_W-1:0]   pat_cnt, pat_cnt_nxt;
  logic               phase, phase_nxt;
  logic [MUTE_W-1:0]  mute_cnt, mute_cnt_nxt;
  logic               muted_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic               beep_nxt;
  logic [FRAME_W-1:0] frame_nxt;
  logic [2:0]         plen_c;
  logic               mute_ok_c;

  // Next state, pattern phase, mute window, speed and output decode.
  always_comb begin
    state_nxt    = level_to_state(acc_level);
    pat_cnt_nxt  = pat_cnt;
    phase_nxt    = phase;
    mute_cnt_nxt = mute_cnt;
    muted_nxt    = muted;
    speed_nxt    = speed;
    beep_nxt     = 1'b0;
    frame_nxt    = FRAME_W'(acc_level);
    plen_c       = phase_len(state, phase, speed);
    mute_ok_c    = ((state == ST_WARN) || (state == ST_DANGER)) &&
                   ((state_nxt == ST_WARN) || (state_nxt == ST_DANGER));

    if (speed_pulse) begin
      speed_nxt = (speed == 2'd2) ? 2'd0 : speed + 2'd1;
    end

    // Every alarm change restarts its pattern in the on / first-frame phase.
    if (state_nxt != state) begin
      pat_cnt_nxt = '0;
      phase_nxt   = 1'b0;
    end else if (tick_c) begin
      if (pat_cnt >= plen_c - 3'd1) begin
        pat_cnt_nxt = '0;
        phase_nxt   = ~phase;
      end else begin
        pat_cnt_nxt = pat_cnt + 3'd1;
      end
    end

    // Escalation or return to NORMAL wins over a coincident mute request.
    if ((state_nxt != state) && ((state_nxt > state) || (state_nxt == ST_NORMAL))) begin
      mute_cnt_nxt = '0;
      muted_nxt    = 1'b0;
    end else if (mute_pulse && mute_ok_c) begin
      mute_cnt_nxt = MUTE_W'(MUTE_TICKS);
      muted_nxt    = 1'b1;
    end else if (tick_c && muted) begin
      mute_cnt_nxt = mute_cnt - MUTE_W'(1);
      muted_nxt    = (mute_cnt != MUTE_W'(1));
    end

    case (state_nxt)
      ST_WARN, ST_DANGER: beep_nxt = ~phase_nxt;
      ST_FLOOD: begin
        beep_nxt  = 1'b1;
        frame_nxt = phase_nxt ? FRAME_FLOOD_FULL : FRAME_FLOOD_BLANK;
      end
      ST_EMERGENCY: begin
        beep_nxt  = 1'b1;
        frame_nxt = phase_nxt ? FRAME_EMERG_B : FRAME_EMERG_A;
      end
      default: beep_nxt = 1'b0;
    endcase

    if (muted_nxt) begin
      beep_nxt = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_NORMAL;
      pat_cnt   <= '0;
      phase     <= 1'b0;
      mute_cnt  <= '0;
      muted     <= 1'b0;
      speed     <= '0;
      beep      <= 1'b0;
      frame_sel <= '0;
    end else begin
      state     <= state_nxt;
      pat_cnt   <= pat_cnt_nxt;
      phase     <= phase_nxt;
      mute_cnt  <= mute_cnt_nxt;
      muted     <= muted_nxt;
      speed     <= speed_nxt;
      beep      <= beep_nxt;
      frame_sel <= frame_nxt;
    end
  end

  assign alarm_state = state;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: vector table, directed corner sequences, random run vs. reference model.
module tb_alarm_scheduler;

  localparam int TD   = 4;
  localparam int CONF = 3;
  localparam int MUTE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] level;
  logic       mute_pulse;
  logic       speed_pulse;
  logic [2:0] alarm_state;
  logic [3:0] frame_sel;
  logic       beep;
  logic       muted;
  logic [1:0] speed;

  alarm_scheduler #(.TICK_DIV(TD), .CONFIRM_TICKS(CONF), .MUTE_TICKS(MUTE)) dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .mute_pulse  (mute_pulse),
    .speed_pulse (speed_pulse),
    .alarm_state (alarm_state),
    .frame_sel   (frame_sel),
    .beep        (beep),
    .muted       (muted),
    .speed       (speed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (edge count since reset, ticks seen, timers as absolute tick numbers).
  int m_n, m_ticks, m_cand, m_cand_ticks, m_acc, m_state;
  int m_t, m_eel, m_ephase, m_mute_end, m_speed;
  int m_beep, m_frame, m_muted;

  typedef struct {
    int lvl;
    int st;
    int fr_lo;
    int fr_hi;
  } vec_t;
  vec_t vecs[8];

  function automatic int lvl_state(input int l);
    if (l == 0) return 0;
    else if (l <= 3) return 1;
    else if (l <= 5) return 2;
    else if (l == 6) return 3;
    else return 4;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, got, lo, hi, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_ticks = 0; m_cand = 0; m_cand_ticks = 0; m_acc = 0; m_state = 0;
    m_t = 0; m_eel = 0; m_ephase = 0; m_mute_end = 0; m_speed = 0;
    m_beep = 0; m_frame = 0; m_muted = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int lv, old_acc, old_state, new_state;
    bit tick, changed;
    if (!rst) begin
      model_reset();
      return;
    end
    lv = int'(level);
    m_n++;
    tick = (m_n % TD == 0);
    old_acc = m_acc;
    old_state = m_state;
    if (lv == 7) m_acc = 7;
    else if (m_cand_ticks >= CONF) m_acc = m_cand;
    if (lv != m_cand) begin
      m_cand = lv;
      m_cand_ticks = 0;
    end else if (tick) begin
      m_cand_ticks++;
    end
    if (tick) m_ticks++;
    new_state = lvl_state(old_acc);
    changed = (new_state != old_state);
    if (changed) begin
      m_t = 0; m_eel = 0; m_ephase = 0;
    end else if (tick) begin
      m_t++;
      if (new_state == 4) begin
        m_eel++;
        if (m_eel >= (4 >> m_speed)) begin
          m_ephase = 1 - m_ephase;
          m_eel = 0;
        end
      end
    end
    if (changed && (new_state > old_state || new_state == 0)) m_mute_end = 0;
    else if (mute_pulse && old_state >= 1 && old_state <= 2 && new_state >= 1 && new_state <= 2)
      m_mute_end = m_ticks + MUTE;
    if (speed_pulse) m_speed = (m_speed + 1) % 3;
    m_state = new_state;
    m_muted = (m_ticks < m_mute_end) ? 1 : 0;
    case (new_state)
      1: begin m_beep = (m_t % 4 == 0) ? 1 : 0; m_frame = old_acc; end
      2: begin m_beep = (m_t % 2 == 0) ? 1 : 0; m_frame = old_acc; end
      3: begin m_beep = 1; m_frame = 6 + (m_t / 2) % 2; end
      4: begin m_beep = 1; m_frame = 8 + m_ephase; end
      default: begin m_beep = 0; m_frame = old_acc; end
    endcase
    if (m_muted != 0) m_beep = 0;
  endtask

  task automatic check_model();
    n_checks++;
    if (int'(alarm_state) != m_state || int'(frame_sel) != m_frame || int'(beep) != m_beep ||
        int'(muted) != m_muted || int'(speed) != m_speed) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got st/fr/bp/mu/sp=%0d/%0d/%0d/%0d/%0d, expected %0d/%0d/%0d/%0d/%0d",
               $time, alarm_state, frame_sel, beep, muted, speed,
               m_state, m_frame, m_beep, m_muted, m_speed);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Assert reset between edges, check outputs cleared at once, then release.
  task automatic do_reset(input int lvl);
    logic [10:0] o;
    #2;
    rst = 1'b0;
    level = 3'(lvl);
    mute_pulse = 1'b0;
    speed_pulse = 1'b0;
    #1;
    model_reset();
    o = {alarm_state, frame_sel, beep, muted, speed};
    check("reset_outputs", int'(o), 0);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_state(input int s, input int max, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (int'(alarm_state) != s && k < max);
  endtask

  task automatic beep_run(input logic val, output int n);
    n = 0;
    while (beep == val && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic frame_run(output int n);
    logic [3:0] f;
    f = frame_sel;
    n = 0;
    while (frame_sel == f && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic pulse_speed();
    speed_pulse = 1'b1;
    step();
    speed_pulse = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, n, bad, hold;
    bit found, seen;
    logic prev;
    logic [10:0] o;

    vecs[0] = '{0, 0, 0, 0};
    vecs[1] = '{1, 1, 1, 1};
    vecs[2] = '{2, 1, 2, 2};
    vecs[3] = '{3, 1, 3, 3};
    vecs[4] = '{4, 2, 4, 4};
    vecs[5] = '{5, 2, 5, 5};
    vecs[6] = '{6, 3, 6, 7};
    vecs[7] = '{7, 4, 8, 9};

    rst = 1'b1;
    level = '0;
    mute_pulse = 1'b0;
    speed_pulse = 1'b0;
    model_reset();

    // Settled alarm class and picture for every level.
    foreach (vecs[i]) begin
      do_reset(vecs[i].lvl);
      repeat (20) step();
      check($sformatf("vec_state_L%0d", vecs[i].lvl), int'(alarm_state), vecs[i].st);
      check_range($sformatf("vec_frame_L%0d", vecs[i].lvl), int'(frame_sel), vecs[i].fr_lo, vecs[i].fr_hi);
    end

    // Level 3 from reset: WARN latency and 4-high / 12-low beep.
    do_reset(3);
    wait_state(1, 40, k);
    check_range("warn_latency", k, 13, 17);
    check("warn_frame", int'(frame_sel), 3);
    prev = beep;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (!prev && beep) found = 1'b1;
      prev = beep;
    end
    check("warn_beep_rise", int'(found), 1);
    for (int r = 0; r < 2; r++) begin
      beep_run(1'b1, n);
      check("warn_beep_high", n, 4);
      beep_run(1'b0, n);
      check("warn_beep_low", n, 12);
    end

    // Short level-4 glitch is filtered out.
    do_reset(0);
    repeat (5) step();
    bad = 0;
    level = 3'd4;
    for (int i = 0; i < 8; i++) begin
      step();
      if (alarm_state != 3'd0 || frame_sel != 4'd0 || beep) bad++;
    end
    level = 3'd0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (alarm_state != 3'd0 || frame_sel != 4'd0 || beep) bad++;
    end
    check("glitch_filtered", bad, 0);

    // Level 7 bypass and emergency animation speeds.
    do_reset(0);
    repeat (3) step();
    level = 3'd7;
    wait_state(4, 10, k);
    check("emerg_latency", k, 2);
    check("emerg_beep", int'(beep), 1);
    frame_run(n);
    frame_run(n);
    check("emerg_s0_period", n, 16);
    pulse_speed();
    pulse_speed();
    check("speed_after_2", int'(speed), 2);
    frame_run(n);
    frame_run(n);
    check("emerg_s2_period", n, 4);
    frame_run(n);
    check("emerg_s2_period_b", n, 4);
    pulse_speed();
    check("speed_wrap", int'(speed), 0);
    frame_run(n);
    frame_run(n);
    check("emerg_s0_again", n, 16);

    // DANGER mute window, then FLOOD escalation mid-mute.
    do_reset(0);
    level = 3'd4;
    wait_state(2, 40, k);
    check("danger_reached", int'(alarm_state), 2);
    repeat (6) step();
    while (m_n % TD != TD - 1) step();
    mute_pulse = 1'b1;
    step();
    mute_pulse = 1'b0;
    check("mute_set", int'(muted), 1);
    n = 0;
    bad = 0;
    while (muted && n < 100) begin
      if (beep) bad++;
      n++;
      step();
    end
    check("mute_len", n, 32);
    check("mute_silent", bad, 0);
    seen = beep;
    for (int i = 0; i < 10; i++) begin
      step();
      if (beep) seen = 1'b1;
    end
    check("beep_resumes", int'(seen), 1);
    mute_pulse = 1'b1;
    step();
    mute_pulse = 1'b0;
    check("mute_set_again", int'(muted), 1);
    repeat (3) step();
    level = 3'd6;
    wait_state(3, 40, k);
    check("flood_mid_mute_state", int'(alarm_state), 3);
    check("flood_clears_mute", int'(muted), 0);
    check("flood_beep", int'(beep), 1);

    // FLOOD blink, mute ignored, asynchronous reset mid-blink.
    check_range("flood_frame", int'(frame_sel), 6, 7);
    frame_run(n);
    frame_run(n);
    check("flood_period", n, 8);
    frame_run(n);
    check("flood_period_b", n, 8);
    mute_pulse = 1'b1;
    step();
    mute_pulse = 1'b0;
    check("flood_mute_ignored", int'(muted), 0);
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    o = {alarm_state, frame_sel, beep, muted, speed};
    check("async_reset_mid_blink", int'(o), 0);
    model_reset();
    level = 3'd0;
    step();
    step();
    rst = 1'b1;
    repeat (20) step();

    // Random levels, pulses and occasional resets against the model.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        level = 3'($urandom_range(0, 7));
        hold = int'($urandom_range(1, 60));
      end
      hold--;
      mute_pulse = ($urandom_range(0, 15) == 0);
      speed_pulse = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 999) == 0) do_reset(0);
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500, clk cycles per internal tick.
REQ-002 SHALL have parameter CONFIRM_TICKS, default 3, ticks a new level must stay stable before it is accepted.
REQ-003 SHALL have parameter MUTE_TICKS, default 8, ticks the beeper stays silenced per mute request.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port level  input  3  raw water level (0..7), sampled every clk.
REQ-007 SHALL have port mute_pulse  input  1  one-cycle debounced mute request.
REQ-008 SHALL have port speed_pulse  input  1  one-cycle debounced animation-speed request.
REQ-009 SHALL have port alarm_state  output  3  NORMAL=0, WARN=1, DANGER=2, FLOOD=3, EMERGENCY=4.
REQ-010 SHALL have port frame_sel  output  4  picture index for the matrix display driver (0..9).
REQ-011 SHALL have port beep  output  1  beeper enable level.
REQ-012 SHALL have port muted  output  1  high while a mute window is active.
REQ-013 SHALL have port speed  output  2  current emergency animation speed (0..2).

Function
REQ-014 SHALL generate a one-clk tick every TICK_DIV clks (counter 0..TICK_DIV-1, tick at wrap).
REQ-015 SHALL filter level with a candidate register: on a mismatch, load the candidate and clear the stable count; on each tick with level==candidate, increment the count; at count==CONFIRM_TICKS, copy the candidate to the accepted level.
REQ-016 SHALL bypass filtering for level 7: it is accepted on the next clk edge.
REQ-017 SHALL register alarm_state one clk after the accepted level changes: 0->NORMAL, 1-3->WARN, 4-5->DANGER, 6->FLOOD, 7->EMERGENCY.
REQ-018 SHALL clear the pattern tick counter and the blink phase on every alarm_state change.
REQ-019 SHALL drive frame_sel = accepted level (0..5) in NORMAL/WARN/DANGER.
REQ-020 SHALL, in FLOOD, alternate frame_sel 6 (blank) and 7 (full), toggling every 2 ticks, starting at 6.
REQ-021 SHALL, in EMERGENCY, alternate frame_sel 8 and 9, toggling every 4/2/1 ticks for speed 0/1/2, starting at 8.
REQ-022 SHALL drive beep as follows: NORMAL 0; WARN 1 tick on, 3 ticks off; DANGER 1 tick on, 1 tick off; FLOOD and EMERGENCY constant 1. Both patterns start in the on phase.
REQ-023 SHALL step speed 0->1->2->0 on each speed_pulse in any state; the new speed applies from the next tick.
REQ-024 SHALL, on mute_pulse in WARN/DANGER, load the mute counter with MUTE_TICKS and set muted; the counter decrements per tick and muted clears at 0.
REQ-025 SHALL force beep=0 while muted.
REQ-026 SHALL reload the mute counter on a mute_pulse while already muted.
REQ-027 SHALL ignore mute_pulse in NORMAL, FLOOD and EMERGENCY.
REQ-028 SHALL clear mute on any transition to a higher alarm_state or to NORMAL; mute is kept on WARN<-DANGER.
REQ-029 SHALL give escalation priority when mute_pulse coincides with an escalating transition, leaving muted=0.

Reset
REQ-030 SHALL on rst low asynchronously set alarm_state=NORMAL, frame_sel=0, beep=0, muted=0, speed=0, and clear the accepted level, candidate, all counters and the phase.
REQ-031 SHALL resume normally from reset asserted mid-operation; no state survives.

Structure
REQ-032 SHALL take the alarm_state encodings, frame_sel codes (0..9) and parameter defaults from shared package alarm_pkg.
REQ-033 SHALL put the tick generator (REQ-014) in sub-module tick_gen; everything else is a single FSM plus counters.

Verification (TICK_DIV=4, CONFIRM_TICKS=3, MUTE_TICKS=8)
REQ-034 SHALL cover: release rst, hold level=3 -> WARN and frame_sel=3 within 13..17 clks; beep 4 clks high, 12 clks low, repeating.
REQ-035 SHALL cover: NORMAL, level=4 for 2 ticks then 0 -> alarm_state stays NORMAL, frame_sel=0, beep=0 throughout.
REQ-036 SHALL cover: level=7 step -> EMERGENCY 2 clks later, beep=1, frame_sel 8/9 toggling every 16 clks; 2 speed_pulses -> every 4 clks; third pulse -> 16 again.
REQ-037 SHALL cover: DANGER, mute_pulse -> muted=1 and beep=0 for 32 clks then pattern resumes; level 6 accepted mid-mute -> muted=0, beep=1.
REQ-038 SHALL cover: FLOOD -> frame_sel 6,7 every 8 clks; mute_pulse ignored; rst low mid-blink -> all outputs 0 immediately, without waiting for a clk edge.
